// File: rtl/demux_8_pkg.sv
// rtl/demux_8_pkg.sv - shared constants, slot record and selector decode for demux_8_reg
package demux_8_pkg;

    localparam int DEMUX_CH     = 8;
    localparam int DEMUX_SEL_W  = 3;
    localparam int DEMUX_DATA_W = 32;

    typedef struct packed {
        logic                    full;
        logic [DEMUX_DATA_W-1:0] data;
    } slot_t;

    function automatic logic [DEMUX_CH-1:0] sel_decode(input logic [DEMUX_SEL_W-1:0] sel);
        logic [DEMUX_CH-1:0] one;
        one = {{(DEMUX_CH-1){1'b0}}, 1'b1};
        return one << sel;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - single-entry holding register with load/drain handshake
module demux_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              full,
    output logic [DATA_W-1:0] data
);

    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;

    // A load wins over a same-cycle drain: the old word leaves, the new one stays.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load) begin
            full_d = 1'b1;
            data_d = load_data;
        end else if (full_q && out_ready) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign data = data_q;

endmodule

// File: rtl/demux_8_reg.sv
// rtl/demux_8_reg.sv - registered 1-to-8 demux; DEMUX8_BROADCAST_EN adds the broadcast input
module demux_8_reg
    import demux_8_pkg::*;
#(
    parameter int DATA_W = DEMUX_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DEMUX_SEL_W-1:0]     seletor,
    input  logic [DATA_W-1:0]          in_data,
`ifdef DEMUX8_BROADCAST_EN
    input  logic                       broadcast,
`endif
    output logic [DEMUX_CH-1:0]        out_valid,
    input  logic [DEMUX_CH-1:0]        out_ready,
    output logic [DEMUX_CH*DATA_W-1:0] out_data,
    output logic                       busy
);

    logic [DEMUX_CH-1:0] full;
    logic [DEMUX_CH-1:0] slot_ok;
    logic [DEMUX_CH-1:0] load;
    logic [DATA_W-1:0]   slot_data [DEMUX_CH];
    logic                ready_w;

    always_comb begin
        slot_ok = ~full | out_ready;
        ready_w = 1'b0;
        load    = '0;
        if (!reset) begin
            ready_w = slot_ok[seletor];
`ifdef DEMUX8_BROADCAST_EN
            if (broadcast) begin
                ready_w = &slot_ok;
            end
`endif
        end
        if (in_valid && ready_w) begin
            load = sel_decode(seletor);
`ifdef DEMUX8_BROADCAST_EN
            if (broadcast) begin
                load = '1;
            end
`endif
        end
    end

    for (genvar k = 0; k < DEMUX_CH; k++) begin : g_slot
        demux_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (load[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .full      (full[k]),
            .data      (slot_data[k])
        );
        assign out_data[k*DATA_W +: DATA_W] = slot_data[k];
    end

    assign in_ready  = ready_w;
    assign out_valid = full;
    assign busy      = |full;

endmodule

// File: tb/tb_demux_8_reg.sv
// tb/tb_demux_8_reg.sv - directed scoreboard bench for demux_8_reg
module tb_demux_8_reg;

    localparam int CH = 8;
    localparam int W  = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    seletor;
    logic [W-1:0]  in_data;
`ifdef DEMUX8_BROADCAST_EN
    logic          broadcast;
`endif
    logic [CH-1:0]   out_valid;
    logic [CH-1:0]   out_ready;
    logic [CH*W-1:0] out_data;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    logic         m_full [CH];
    logic [W-1:0] m_data [CH];
    logic [W-1:0] sb_q   [CH][$];
    int           recv_cnt [CH];
    int           base_cnt [CH];

    always #5 clk = ~clk;

    demux_8_reg #(.DATA_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .seletor   (seletor),
        .in_data   (in_data),
`ifdef DEMUX8_BROADCAST_EN
        .broadcast (broadcast),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks the current cycle against the model at the falling edge, then
    // advances the model across the next rising edge.
    task automatic tick();
        logic exp_ready;
        logic bc;
        logic [W-1:0] w;
        @(negedge clk);
        bc = 1'b0;
`ifdef DEMUX8_BROADCAST_EN
        bc = broadcast;
`endif
        exp_ready = 1'b0;
        if (!reset) begin
            if (bc) begin
                exp_ready = 1'b1;
                for (int k = 0; k < CH; k++)
                    if (m_full[k] && !out_ready[k]) exp_ready = 1'b0;
            end else begin
                exp_ready = !m_full[seletor] || out_ready[seletor];
            end
        end
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
        for (int k = 0; k < CH; k++) begin
            chk($sformatf("out_valid[%0d]", k), {63'd0, out_valid[k]}, {63'd0, m_full[k]});
            chk($sformatf("out_data[%0d]", k), {32'd0, out_data[k*W +: W]}, {32'd0, m_data[k]});
        end
        chk("busy", {63'd0, busy}, {63'd0, (sb_q[0].size() + sb_q[1].size() + sb_q[2].size() +
            sb_q[3].size() + sb_q[4].size() + sb_q[5].size() + sb_q[6].size() + sb_q[7].size()) != 0});
        if (reset) begin
            for (int k = 0; k < CH; k++) begin
                m_full[k] = 1'b0;
                m_data[k] = '0;
                sb_q[k].delete();
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (m_full[k] && out_ready[k]) begin
                    if (sb_q[k].size() == 0) begin
                        chk($sformatf("sb_empty[%0d]", k), 64'd0, 64'd1);
                    end else begin
                        w = sb_q[k].pop_front();
                        chk($sformatf("drain_word[%0d]", k), {32'd0, out_data[k*W +: W]}, {32'd0, w});
                    end
                    recv_cnt[k]++;
                    m_full[k] = 1'b0;
                end
            end
            if (in_valid && exp_ready) begin
                for (int k = 0; k < CH; k++) begin
                    if (bc || (k == int'(seletor))) begin
                        m_full[k] = 1'b1;
                        m_data[k] = in_data;
                        sb_q[k].push_back(in_data);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < CH; k++) begin
            m_full[k]   = 1'b0;
            m_data[k]   = '0;
            recv_cnt[k] = 0;
            base_cnt[k] = 0;
        end
        reset     = 1'b1;
        in_valid  = 1'b1;
        seletor   = 3'd1;
        in_data   = 32'h0BAD_0001;
        out_ready = '0;
`ifdef DEMUX8_BROADCAST_EN
        broadcast = 1'b0;
`endif
        @(posedge clk);
        #1;
        tick();
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("reset_out_valid", {56'd0, out_valid}, 64'h00);
        chk("reset_busy", {63'd0, busy}, 64'd0);

        seletor  = 3'd5;
        in_data  = 32'hDEAD_BEEF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("tp1_out_valid", {56'd0, out_valid}, 64'h20);
        chk("tp1_slice5", {32'd0, out_data[5*W +: W]}, 64'hDEAD_BEEF);
        chk("tp1_busy", {63'd0, busy}, 64'd1);
        tick();

        seletor  = 3'd5;
        in_data  = 32'h1234_5678;
        in_valid = 1'b1;
        #1;
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("stall_hold5", {32'd0, out_data[5*W +: W]}, 64'hDEAD_BEEF);
        seletor = 3'd2;
        in_data = 32'hCAFE_F00D;
        tick();
        in_valid = 1'b0;
        chk("tp2_out_valid", {56'd0, out_valid}, 64'h24);
        tick();
        out_ready = 8'h24;
        tick();
        out_ready = '0;

        seletor  = 3'd3;
        in_data  = 32'hAAAA_0003;
        in_valid = 1'b1;
        tick();
        out_ready = 8'h08;
        in_data   = 32'h0000_0011;
        tick();
        in_valid  = 1'b0;
        out_ready = '0;
        tick();
        chk("flow_valid3", {63'd0, out_valid[3]}, 64'd1);
        chk("flow_slice3", {32'd0, out_data[3*W +: W]}, 64'h11);
        chk("flow_cnt3_prior", recv_cnt[3], 64'd1);
        out_ready = 8'h08;
        tick();
        out_ready = '0;
        chk("flow_cnt3_after", recv_cnt[3], 64'd2);

        for (int k = 0; k < CH; k++) base_cnt[k] = recv_cnt[k];
        out_ready = 8'hFF;
        in_valid  = 1'b1;
        for (int i = 0; i < CH; i++) begin
            seletor = 3'(i);
            in_data = 32'(i + 1);
            #1;
            chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        for (int k = 0; k < CH; k++)
            chk($sformatf("stream_cnt[%0d]", k), recv_cnt[k], base_cnt[k] + 1);
        out_ready = '0;

        in_valid = 1'b1;
        for (int i = 0; i < CH; i++) begin
            seletor = 3'(i);
            in_data = 32'h0000_0100 + 32'(i);
            tick();
        end
        chk("fill_out_valid", {56'd0, out_valid}, 64'hFF);
        reset   = 1'b1;
        seletor = 3'd0;
        in_data = 32'h0BAD_0BAD;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rst_mid_out_valid", {56'd0, out_valid}, 64'h00);
        chk("rst_mid_out_data_zero", {63'd0, out_data == '0}, 64'd1);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        tick();

`ifdef DEMUX8_BROADCAST_EN
        seletor  = 3'd6;
        in_data  = 32'h0000_0066;
        in_valid = 1'b1;
        tick();
        broadcast = 1'b1;
        seletor   = 3'd1;
        in_data   = 32'hA5A5_A5A5;
        #1;
        chk("bc_stall_ready", {63'd0, in_ready}, 64'd0);
        tick();
        out_ready = 8'h40;
        #1;
        chk("bc_drain_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid  = 1'b0;
        broadcast = 1'b0;
        out_ready = '0;
        chk("bc_out_valid", {56'd0, out_valid}, 64'hFF);
        for (int k = 0; k < CH; k++)
            chk($sformatf("bc_slice[%0d]", k), {32'd0, out_data[k*W +: W]}, 64'hA5A5_A5A5);
        tick();
        out_ready = 8'hFF;
        tick();
        out_ready = '0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
